// File: rtl/div_iter.sv
// -----------------------------------------------------------------------------
// div_iter -- iterative radix-2 restoring divider (EX-stage divide responder)
//
// Produces one quotient bit per clock, MSB first, over WIDTH cycles. Signed
// operation divides magnitudes and fixes the result signs on completion
// (truncating division: remainder takes the dividend's sign). Divide-by-zero
// bypasses the iteration and returns {dividend, all-ones}.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   start_i     request, held high by EX while waiting; dropping it cancels
//   annul_i     pipeline flush; aborts any operation (wins over start_i)
//   signed_i    1 = signed divide, 0 = unsigned
//   dividend_i  dividend, sampled in IDLE when a request is accepted
//   divider_i   divisor, sampled together with dividend_i
//   result_o    {remainder, quotient}, registered, changes only on success
//   success_o   one-cycle pulse, result_o valid
//   busy_o      high while iterating
// -----------------------------------------------------------------------------
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 annul_i,
    input  logic                 signed_i,
    input  logic [WIDTH-1:0]     dividend_i,
    input  logic [WIDTH-1:0]     divider_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 success_o,
    output logic                 busy_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CALC  = 2'd1;
    localparam logic [1:0] ST_DZERO = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int              CW        = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   CNT_LAST  = CW'(WIDTH - 1);
    localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
    localparam logic [CW-1:0]   CNT_ZERO  = CW'(0);
    localparam logic [WIDTH-1:0] W_ZERO   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] W_ONES   = {WIDTH{1'b1}};

    // Two's-complement negate; the most negative value maps onto itself,
    // which is exactly the unsigned magnitude we want for it.
    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return (~v) + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Magnitude of a signed operand.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? negate(v) : v;
    endfunction

    logic [1:0]         state_r;
    logic [CW-1:0]      cnt_r;
    logic [WIDTH-1:0]   dvd_r;      // dividend shifting out MSB-first, quotient bits shifting in
    logic [WIDTH-1:0]   dsr_r;      // divisor magnitude
    logic [WIDTH-1:0]   rem_r;      // partial remainder
    logic               sign_q_r;
    logic               sign_r_r;
    logic [2*WIDTH-1:0] result_r;
    logic               success_r;
    logic               busy_r;

    logic [WIDTH-1:0]   partial_s;
    logic [WIDTH:0]     trial_s;
    logic               qbit_s;
    logic [WIDTH-1:0]   rem_next_s;
    logic [WIDTH-1:0]   quot_next_s;
    logic [WIDTH-1:0]   rem_fin_s;
    logic [WIDTH-1:0]   quot_fin_s;
    logic               abort_s;

    // One restoring step plus the sign-corrected final values.
    // The partial remainder can only reach the top bit on the last step, so
    // dropping rem_r's MSB on the shift never loses information.
    always_comb begin
        partial_s   = {rem_r[WIDTH-2:0], dvd_r[WIDTH-1]};
        trial_s     = {1'b0, partial_s} - {1'b0, dsr_r};
        qbit_s      = ~trial_s[WIDTH];
        if (qbit_s) begin
            rem_next_s = trial_s[WIDTH-1:0];
        end else begin
            rem_next_s = partial_s;
        end
        quot_next_s = {dvd_r[WIDTH-2:0], qbit_s};
        if (sign_q_r) begin
            quot_fin_s = negate(quot_next_s);
        end else begin
            quot_fin_s = quot_next_s;
        end
        if (sign_r_r) begin
            rem_fin_s = negate(rem_next_s);
        end else begin
            rem_fin_s = rem_next_s;
        end
        abort_s     = annul_i | ~start_i;
    end

    // Control FSM, operand capture, iteration datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= CNT_ZERO;
            dvd_r     <= W_ZERO;
            dsr_r     <= W_ZERO;
            rem_r     <= W_ZERO;
            sign_q_r  <= 1'b0;
            sign_r_r  <= 1'b0;
            result_r  <= {W_ZERO, W_ZERO};
            success_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            success_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start_i && !annul_i) begin
                        cnt_r    <= CNT_ZERO;
                        rem_r    <= W_ZERO;
                        sign_q_r <= signed_i & (dividend_i[WIDTH-1] ^ divider_i[WIDTH-1]);
                        sign_r_r <= signed_i & dividend_i[WIDTH-1];
                        dsr_r    <= signed_i ? magnitude(divider_i) : divider_i;
                        if (divider_i == W_ZERO) begin
                            // Divide-by-zero reports the raw dividend as remainder.
                            dvd_r   <= dividend_i;
                            state_r <= ST_DZERO;
                        end else begin
                            dvd_r   <= signed_i ? magnitude(dividend_i) : dividend_i;
                            busy_r  <= 1'b1;
                            state_r <= ST_CALC;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    if (abort_s) begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        rem_r <= rem_next_s;
                        dvd_r <= quot_next_s;
                        cnt_r <= cnt_r + CNT_ONE;
                        if (cnt_r == CNT_LAST) begin
                            result_r  <= {rem_fin_s, quot_fin_s};
                            success_r <= 1'b1;
                            busy_r    <= 1'b0;
                            state_r   <= ST_DONE;
                        end else begin
                            state_r <= ST_CALC;
                        end
                    end
                end
                ST_DZERO: begin
                    if (abort_s) begin
                        state_r <= ST_IDLE;
                    end else begin
                        result_r  <= {dvd_r, W_ONES};
                        success_r <= 1'b1;
                        state_r   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // No handshake wait: a still-high start_i re-issues from IDLE.
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign result_o  = result_r;
    assign success_o = success_r;
    assign busy_o    = busy_r;

endmodule
